sub_serial: RTL and testbench

Bit-serial subtractor computing `a - b` (mod 2^WIDTH) one bit per clock, LSB first. It is the inverse-operation companion of the bit-serial adder in the same datapath library. It uses the same start/result style: a level `en` request, parallel operands captured once, and a parallel result assembled in a shift register. It also adds a final borrow flag and an explicit `done` indication, so a controller can chain add/sub operations without counting cycles.

---
 rtl/sub_serial.sv | 87 ++++++++
 tb/tb_sub_serial.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/sub_serial.sv
// sub_serial: bit-serial subtractor a - b (mod 2^WIDTH), LSB first, one bit per clock.
// Ports:
//   clk    - clock, rising edge
//   rst    - asynchronous active-high reset
//   en     - start request (level), sampled in IDLE and DONE only
//   a, b   - minuend / subtrahend, captured on the accepting edge
//   out    - difference register, valid while done=1
//   borrow - final borrow-out (a < b unsigned), valid while done=1
//   done   - high while the result is held
module sub_serial #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic             borrow,
    output logic             done
);
    localparam logic [1:0] IDLE = 2'd0, SUB = 2'd1, DONE = 2'd2;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, out_q, out_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             brw_q, brw_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            out_q   <= '0;
            count_q <= '0;
            brw_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            out_q   <= out_d;
            count_q <= count_d;
            brw_q   <= brw_d;
        end
    end

    // next-state; the unused encoding falls back to IDLE
    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = en ? SUB : IDLE;
            SUB:     state_d = (count_q == LAST) ? DONE : SUB;
            DONE:    state_d = en ? DONE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        out_d   = out_q;
        count_d = count_q;
        brw_d   = brw_q;
        if (state_q == IDLE && en) begin
            a_d     = a;
            b_d     = b;
            out_d   = '0;
            count_d = '0;
            brw_d   = 1'b0;
        end else if (state_q == SUB) begin
            // full subtractor on the current LSBs; result enters at the MSB and shifts down
            out_d   = {a_q[0] ^ b_q[0] ^ brw_q, out_q[WIDTH-1:1]};
            brw_d   = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & brw_q);
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            count_d = count_q + 1'b1;
        end
    end

    always_comb begin
        done   = (state_q == DONE);
        out    = out_q;
        borrow = brw_q;
    end
endmodule

// File: tb/tb_sub_serial.sv
// tb_sub_serial: self-checking bench for sub_serial against a result-level model.
module tb_sub_serial;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic [WIDTH-1:0] a = '0, b = '0;
    logic [WIDTH-1:0] out;
    logic             borrow, done;

    int n_cmp = 0, n_bad = 0;

    sub_serial #(.WIDTH(WIDTH), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .en(en), .a(a), .b(b),
        .out(out), .borrow(borrow), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // model: result is plain a-b and a<b; done appears WIDTH edges after accept
    logic             m_busy = 1'b0, m_done = 1'b0, m_brw = 1'b0;
    int               m_left = 0;
    logic [WIDTH-1:0] m_out = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_left <= 0;
        end else if (m_done) begin
            m_done <= en;
        end else if (m_busy) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
            end
        end else if (en) begin
            m_busy <= 1'b1;
            m_left <= WIDTH;
            m_out  <= a - b;
            m_brw  <= (a < b);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("cyc_done", 32'(done), 32'(m_done));
            if (m_done) begin
                chk("cyc_out", 32'(out), 32'(m_out));
                chk("cyc_borrow", 32'(borrow), 32'(m_brw));
            end
        end
    end

    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v,
                          input logic [7:0] eo, input logic eb, input bit toggle);
        int k = 0;
        @(negedge clk);
        a = ta; b = tb_v; en = 1'b1;
        for (int i = 1; i <= 20 && k == 0; i++) begin
            @(negedge clk);
            if (i == 1) en = 1'b0;
            if (toggle) begin a = 8'($urandom); b = 8'($urandom); end
            if (done) k = i;
        end
        chk("latency", 32'(k), 32'(WIDTH + 1));
        chk("out", 32'(out), 32'(eo));
        chk("borrow", 32'(borrow), 32'(eb));
        chk("model_out", 32'(m_out), 32'(eo));
        chk("model_brw", 32'(m_brw), 32'(eb));
        @(negedge clk);
        chk("idle_after", 32'(done), 32'd0);
    endtask

    initial begin
        #1;
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_borrow", 32'(borrow), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        run_op(8'h5A, 8'h23, 8'h37, 1'b0, 1'b0);
        run_op(8'h10, 8'h20, 8'hF0, 1'b1, 1'b0);
        run_op(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
        run_op(8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0);

        // en held through completion
        @(negedge clk);
        a = 8'h5A; b = 8'h23; en = 1'b1;
        for (int i = 0; i < 20 && !done; i++) @(negedge clk);
        chk("held_done", 32'(done), 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("held_stay", 32'(done), 32'd1);
            chk("held_out", 32'(out), 32'h37);
        end
        en = 1'b0;
        @(negedge clk);
        chk("held_release", 32'(done), 32'd0);
        run_op(8'h80, 8'h7F, 8'h01, 1'b0, 1'b0);

        // operands scrambled during SUB must not matter
        run_op(8'hC3, 8'h3C, 8'h87, 1'b0, 1'b1);
        run_op(8'h01, 8'hA0, 8'h61, 1'b1, 1'b1);

        // reset four edges into SUB
        @(negedge clk);
        a = 8'h5A; b = 8'h23; en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        for (int i = 0; i < 4; i++) @(negedge clk);
        chk("partial_nonzero", 32'(out != 0), 32'd1);
        rst = 1'b1;
        #1;
        chk("async_out", 32'(out), 32'd0);
        chk("async_borrow", 32'(borrow), 32'd0);
        chk("async_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(8'h33, 8'h44, 8'hEF, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule
